// File: rtl/mem_responder_pkg.sv
// Shared bus definitions: command codes, the no-op instruction and the word-address helper.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  // addi x0, x0, 0
  localparam logic [31:0] NOOP_INST = 32'h0000_0013;

  // Byte address to word address; callers slice the low index bits.
  function automatic logic [29:0] word_addr(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word-wide storage: two asynchronous read ports and one synchronous write port.
// Contents are never reset.
module mem_responder_mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             i_clk,
  input  logic [IDX_W-1:0] i_raddr_a,
  output logic [31:0]      o_rdata_a,
  input  logic [IDX_W-1:0] i_raddr_b,
  output logic [31:0]      o_rdata_b,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

  // Single write port, driven by the top-level arbiter.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the instruction and data buses: zero-latency reads, stores posted
// through a one-entry write buffer with forwarding, a preload port, sticky error flags and
// access counters.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_pc_addr,
  input  logic [1:0]       i_im_command,
  output logic [31:0]      o_instruction,
  input  logic [31:0]      i_proc2Dmem_addr,
  input  logic [1:0]       i_proc2Dmem_command,
  input  logic [31:0]      i_proc2mem_data,
  output logic [31:0]      o_mem2proc_data,
  input  logic             i_ld_valid,
  input  logic [31:0]      i_ld_addr,
  input  logic [31:0]      i_ld_data,
  output logic             o_ld_ready,
  output logic             o_misalign_err,
  output logic             o_oob_err,
  output logic [CNT_W-1:0] o_load_cnt,
  output logic [CNT_W-1:0] o_store_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic             r_wbuf_valid;
  logic [IDX_W-1:0] r_wbuf_idx;
  logic [31:0]      r_wbuf_data;
  logic             r_misalign_err;
  logic             r_oob_err;
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_store_cnt;

  logic [29:0]      w_if_wa, w_dm_wa, w_ld_wa;
  logic [IDX_W-1:0] w_if_idx, w_dm_idx, w_ld_idx;
  logic             w_if_oob, w_dm_oob, w_ld_oob;
  logic             w_if_mis, w_dm_mis, w_ld_mis;
  logic             w_if_load, w_dm_load, w_dm_store, w_ld_take;
  logic             w_store_ok, w_drain_we, w_ld_we;
  logic             w_mis_any, w_oob_any;
  logic [31:0]      w_if_rdata, w_dm_rdata, w_if_word, w_dm_word;
  logic             w_arr_we;
  logic [IDX_W-1:0] w_arr_waddr;
  logic [31:0]      w_arr_wdata;

  // Address decode: out of range whenever any bit above the index field is set.
  assign w_if_wa  = word_addr(i_pc_addr);
  assign w_dm_wa  = word_addr(i_proc2Dmem_addr);
  assign w_ld_wa  = word_addr(i_ld_addr);
  assign w_if_idx = w_if_wa[IDX_W-1:0];
  assign w_dm_idx = w_dm_wa[IDX_W-1:0];
  assign w_ld_idx = w_ld_wa[IDX_W-1:0];
  assign w_if_oob = |w_if_wa[29:IDX_W];
  assign w_dm_oob = |w_dm_wa[29:IDX_W];
  assign w_ld_oob = |w_ld_wa[29:IDX_W];
  assign w_if_mis = |i_pc_addr[1:0];
  assign w_dm_mis = |i_proc2Dmem_addr[1:0];
  assign w_ld_mis = |i_ld_addr[1:0];

  assign w_if_load  = (i_im_command == BUS_LOAD);
  assign w_dm_load  = (i_proc2Dmem_command == BUS_LOAD);
  assign w_dm_store = (i_proc2Dmem_command == BUS_STORE);
  assign w_ld_take  = i_ld_valid && o_ld_ready;
  assign w_store_ok = w_dm_store && !w_dm_oob;

  assign w_mis_any = (w_if_load && w_if_mis) || ((w_dm_load || w_dm_store) && w_dm_mis) ||
                     (w_ld_take && w_ld_mis);
  assign w_oob_any = (w_if_load && w_if_oob) || ((w_dm_load || w_dm_store) && w_dm_oob) ||
                     (w_ld_take && w_ld_oob);

  // Forwarding: the buffered store is newer than the array word.
  assign w_if_word = (r_wbuf_valid && (r_wbuf_idx == w_if_idx)) ? r_wbuf_data : w_if_rdata;
  assign w_dm_word = (r_wbuf_valid && (r_wbuf_idx == w_dm_idx)) ? r_wbuf_data : w_dm_rdata;

  assign o_instruction   = (w_if_load && !w_if_oob) ? w_if_word : NOOP_INST;
  assign o_mem2proc_data = (w_dm_load && !w_dm_oob) ? w_dm_word : 32'h0;

  // Drain is skipped under reset (entry discarded) and when a same-index store overwrites it.
  assign w_drain_we = r_wbuf_valid && !i_rst && !(w_store_ok && (w_dm_idx == r_wbuf_idx));
  assign w_ld_we    = w_ld_take && !w_ld_oob;

  // Write-port arbitration: drain wins over preload.
  always_comb begin
    w_arr_we    = 1'b0;
    w_arr_waddr = w_ld_idx;
    w_arr_wdata = i_ld_data;
    if (w_drain_we) begin
      w_arr_we    = 1'b1;
      w_arr_waddr = r_wbuf_idx;
      w_arr_wdata = r_wbuf_data;
    end else if (w_ld_we) begin
      w_arr_we    = 1'b1;
    end
  end

  mem_responder_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem_array (
    .i_clk     (i_clk),
    .i_raddr_a (w_if_idx),
    .o_rdata_a (w_if_rdata),
    .i_raddr_b (w_dm_idx),
    .o_rdata_b (w_dm_rdata),
    .i_we      (w_arr_we),
    .i_waddr   (w_arr_waddr),
    .i_wdata   (w_arr_wdata)
  );

  // Write buffer, sticky error flags and access counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wbuf_valid   <= 1'b0;
      r_misalign_err <= 1'b0;
      r_oob_err      <= 1'b0;
      r_load_cnt     <= '0;
      r_store_cnt    <= '0;
    end else begin
      r_wbuf_valid <= w_store_ok;
      if (w_store_ok) begin
        r_wbuf_idx  <= w_dm_idx;
        r_wbuf_data <= i_proc2mem_data;
      end
      if (w_mis_any) r_misalign_err <= 1'b1;
      if (w_oob_any) r_oob_err <= 1'b1;
      if (w_dm_load) r_load_cnt <= r_load_cnt + CNT_W'(1);
      if (w_dm_store) r_store_cnt <= r_store_cnt + CNT_W'(1);
    end
  end

  assign o_ld_ready     = ~r_wbuf_valid;
  assign o_misalign_err = r_misalign_err;
  assign o_oob_err      = r_oob_err;
  assign o_load_cnt     = r_load_cnt;
  assign o_store_cnt    = r_store_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the stimulus pushes per-cycle expectations, a monitor
// on the falling edge pops and compares them against the DUT outputs.
module tb_mem_responder;

  localparam logic [1:0]  NONE  = 2'd0;
  localparam logic [1:0]  LOAD  = 2'd1;
  localparam logic [1:0]  STORE = 2'd2;
  localparam logic [31:0] NOOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr, dm_addr, st_data, ld_addr, ld_data;
  logic [1:0]  im_cmd, dm_cmd;
  logic        ld_valid;
  logic [31:0] instruction, rdata, load_cnt, store_cnt;
  logic        ld_ready, mis_err, oob_err;

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH_WORDS (1024),
    .CNT_W       (32)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_pc_addr           (pc_addr),
    .i_im_command        (im_cmd),
    .o_instruction       (instruction),
    .i_proc2Dmem_addr    (dm_addr),
    .i_proc2Dmem_command (dm_cmd),
    .i_proc2mem_data     (st_data),
    .o_mem2proc_data     (rdata),
    .i_ld_valid          (ld_valid),
    .i_ld_addr           (ld_addr),
    .i_ld_data           (ld_data),
    .o_ld_ready          (ld_ready),
    .o_misalign_err      (mis_err),
    .o_oob_err           (oob_err),
    .o_load_cnt          (load_cnt),
    .o_store_cnt         (store_cnt)
  );

  typedef struct {
    logic [31:0] d;
    logic [31:0] i;
    bit          chk;
    logic        mis;
    logic        oob;
    logic [31:0] lc;
    logic [31:0] sc;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("mem2proc_data", rdata, e.d);
      chk("instruction", instruction, e.i);
      if (e.chk) begin
        chk("misalign_err", {31'b0, mis_err}, {31'b0, e.mis});
        chk("oob_err", {31'b0, oob_err}, {31'b0, e.oob});
        chk("load_cnt", load_cnt, e.lc);
        chk("store_cnt", store_cnt, e.sc);
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, e.rdy});
      end
    end
  end

  // Status expected to be visible during the next driven cycle.
  task automatic expect_status(input logic mis, input logic oob, input logic [31:0] lc,
                               input logic [31:0] sc, input logic rdy);
    pend.chk = 1'b1;
    pend.mis = mis;
    pend.oob = oob;
    pend.lc  = lc;
    pend.sc  = sc;
    pend.rdy = rdy;
  endtask

  task automatic drive(input logic r, input logic [1:0] dc, input logic [31:0] da,
                       input logic [31:0] dd, input logic [1:0] ic, input logic [31:0] ia,
                       input logic [31:0] ed, input logic [31:0] ei);
    rst     = r;
    dm_cmd  = dc;
    dm_addr = da;
    st_data = dd;
    im_cmd  = ic;
    pc_addr = ia;
    pend.d  = ed;
    pend.i  = ei;
    exp_q.push_back(pend);
    pend.chk = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    drive(1'b1, NONE, 32'h0, 32'h0, NONE, 32'h0, 32'h0, NOOP);
    ld_valid = 1'b0;
  endtask

  initial begin
    pend     = '{default: '0};
    rst      = 1'b1;
    ld_valid = 1'b0;
    ld_addr  = 32'h0;
    ld_data  = 32'h0;
    dm_cmd   = NONE;
    dm_addr  = 32'h0;
    st_data  = 32'h0;
    im_cmd   = NONE;
    pc_addr  = 32'h0;
    @(posedge clk);
    #1;
    drive(1'b1, NONE, 32'h0, 32'h0, NONE, 32'h0, 32'h0, NOOP);
    // Preload image while reset is held.
    preload(32'h00, 32'h0000_0013);
    preload(32'h04, 32'h1234_5678);
    preload(32'h10, 32'h1111_1111);
    preload(32'h20, 32'h2020_2020);
    preload(32'h24, 32'h2424_2424);
    preload(32'h30, 32'h0BAD_F00D);

    // Fetch 0x4 and load 0x0 together.
    expect_status(1'b0, 1'b0, 0, 0, 1'b1);
    drive(1'b0, LOAD, 32'h00, 32'h0, LOAD, 32'h04, 32'h0000_0013, 32'h1234_5678);
    // Store, then read back via forwarding on both ports, then from the array.
    expect_status(1'b0, 1'b0, 1, 0, 1'b1);
    drive(1'b0, STORE, 32'h10, 32'hCAFE_F00D, NONE, 32'h0, 32'h0, NOOP);
    expect_status(1'b0, 1'b0, 1, 1, 1'b0);
    drive(1'b0, LOAD, 32'h10, 32'h0, LOAD, 32'h10, 32'hCAFE_F00D, 32'hCAFE_F00D);
    expect_status(1'b0, 1'b0, 2, 1, 1'b1);
    drive(1'b0, NONE, 32'h10, 32'h0, NONE, 32'h10, 32'h0, NOOP);
    drive(1'b0, LOAD, 32'h10, 32'h0, LOAD, 32'h10, 32'hCAFE_F00D, 32'hCAFE_F00D);
    // Back-to-back stores; second one drains the first.
    expect_status(1'b0, 1'b0, 3, 1, 1'b1);
    drive(1'b0, STORE, 32'h20, 32'h1, NONE, 32'h0, 32'h0, NOOP);
    expect_status(1'b0, 1'b0, 3, 2, 1'b0);
    drive(1'b0, STORE, 32'h24, 32'h2, LOAD, 32'h20, 32'h0, 32'h1);
    expect_status(1'b0, 1'b0, 3, 3, 1'b0);
    drive(1'b0, LOAD, 32'h20, 32'h0, LOAD, 32'h24, 32'h1, 32'h2);
    expect_status(1'b0, 1'b0, 4, 3, 1'b1);
    drive(1'b0, LOAD, 32'h24, 32'h0, NONE, 32'h0, 32'h2, NOOP);
    // Misaligned load uses the aligned word; flag is sticky.
    expect_status(1'b0, 1'b0, 5, 3, 1'b1);
    drive(1'b0, LOAD, 32'h22, 32'h0, NONE, 32'h0, 32'h1, NOOP);
    expect_status(1'b1, 1'b0, 6, 3, 1'b1);
    drive(1'b0, NONE, 32'h0, 32'h0, NONE, 32'h0, 32'h0, NOOP);
    // Out-of-range load and fetch, then a dropped out-of-range store.
    expect_status(1'b1, 1'b0, 6, 3, 1'b1);
    drive(1'b0, LOAD, 32'h1000, 32'h0, LOAD, 32'h1000, 32'h0, NOOP);
    expect_status(1'b1, 1'b1, 7, 3, 1'b1);
    drive(1'b0, STORE, 32'h1000, 32'hDEAD_BEEF, NONE, 32'h0, 32'h0, NOOP);
    expect_status(1'b1, 1'b1, 7, 4, 1'b1);
    drive(1'b0, LOAD, 32'h00, 32'h0, LOAD, 32'h00, 32'h0000_0013, 32'h0000_0013);
    // Store immediately followed by reset: entry discarded.
    expect_status(1'b1, 1'b1, 8, 4, 1'b1);
    drive(1'b0, STORE, 32'h30, 32'h0000_0055, NONE, 32'h0, 32'h0, NOOP);
    expect_status(1'b1, 1'b1, 8, 5, 1'b0);
    drive(1'b1, NONE, 32'h0, 32'h0, NONE, 32'h0, 32'h0, NOOP);
    expect_status(1'b0, 1'b0, 0, 0, 1'b1);
    drive(1'b0, LOAD, 32'h30, 32'h0, LOAD, 32'h30, 32'h0BAD_F00D, 32'h0BAD_F00D);
    expect_status(1'b0, 1'b0, 1, 0, 1'b1);
    drive(1'b0, NONE, 32'h0, 32'h0, NONE, 32'h0, 32'h0, NOOP);

    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
